uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver: 8 data bits, LSB first, one start bit, one stop bit, no parity.
- Counterpart to the team's uart_tx; shares the same CLKS_PER_BIT convention, so one parameter value pairs a TX/RX link.
- Recovers bytes from the asynchronous serial line by sampling at mid-bit.
- Presents each received byte with a one-cycle valid pulse; flags framing errors.

Parameters:
- CLKS_PER_BIT, 100, clock cycles per UART bit = f(i_Clock)/baud. Legal range 4..1023; the counter is 10 bits.

Ports:
- i_Clock  input  1  system clock; all logic on posedge.
- i_Reset  input  1  synchronous, active-high reset.
- i_Rx_Serial  input  1  asynchronous serial line; idle high.
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_Byte holds a new valid byte.
- o_Rx_Byte  output  8  last correctly framed byte; held until the next valid byte.
- o_Rx_Active  output  1  high from start-bit qualification until the frame completes or is aborted.
- o_Rx_Frame_Err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset (synchronous, active-high, priority over all else):
  - outputs: o_Rx_DV=0, o_Rx_Byte=8'h00, o_Rx_Active=0, o_Rx_Frame_Err=0.
  - synchronizer flops=1, state=IDLE, counters=0.
  - Reset mid-frame aborts the frame with no DV or error pulse.
- Input sync: 2-flop synchronizer on i_Rx_Serial, both flops power-up/reset to 1. All FSM decisions use the second flop (rx_s). This adds 2 cycles of fixed latency.
- Let H = (CLKS_PER_BIT-1)/2, integer division.
- States and transitions:
  - IDLE: counter=0, bit index=0. rx_s==0 -> START.
  - START: counter increments each cycle. When counter==H, sample rx_s:
    - 0 -> counter=0, o_Rx_Active=1, go DATA.
    - 1 -> glitch; return to IDLE with no output activity.
  - DATA: counter counts 0..CLKS_PER_BIT-1. At CLKS_PER_BIT-1, sample rx_s into shift/index bit [bit index] and clear the counter. After index 7 go STOP, otherwise increment the index.
  - STOP: at counter==CLKS_PER_BIT-1, sample rx_s:
    - 1 -> load o_Rx_Byte, pulse o_Rx_DV for one cycle, go CLEANUP.
    - 0 -> pulse o_Rx_Frame_Err for one cycle; o_Rx_Byte unchanged; go WAIT_HIGH.
  - CLEANUP: one cycle; o_Rx_Active=0; go IDLE.
  - WAIT_HIGH: o_Rx_Active=0; stay until rx_s==1, then go IDLE. This ensures a held-low (break) line gives exactly one error.
  - Any undefined encoding -> IDLE.
- Timing:
  - Sampling points are mid-bit: start at H; data/stop at H + k*CLKS_PER_BIT, with cycles measured from rx_s falling.
  - o_Rx_DV rises 2 + H + 9*CLKS_PER_BIT + 1 cycles (±1 cycle) after the i_Rx_Serial falling edge.
- Simultaneous events: o_Rx_DV and o_Rx_Frame_Err are never high together.
- Back-to-back: a start bit that follows a stop bit immediately must be received. CLEANUP plus IDLE consume at most 2 cycles of the remaining half stop bit.
- o_Rx_Byte changes only in the cycle o_Rx_DV is asserted.

Test Plan:
- CLKS_PER_BIT=8 for all benches; stimulus driven by the team's uart_tx or a bench driver.
- Single frame 8'hA5 -> exactly one o_Rx_DV pulse with o_Rx_Byte=8'hA5. o_Rx_Frame_Err stays 0. o_Rx_Active is high across the frame and low 1 cycle after DV.
- Back-to-back 8'h00 then 8'hFF with no idle gap -> two DV pulses, bytes 8'h00 then 8'hFF, no errors.
- Low glitch of 2 cycles on an idle line -> no DV, no error, o_Rx_Active never asserted. A following frame 8'h3C is received correctly.
- Frame 8'h5A with stop bit forced 0, line then returned high -> o_Rx_Frame_Err pulses once, no DV, o_Rx_Byte keeps its prior value (8'h3C). The next frame 8'h81 is received correctly.
- Line held low for 20 bit times, then high -> exactly one o_Rx_Frame_Err pulse, no DV. Receiver returns to IDLE once the line goes high.
- i_Reset asserted for 1 cycle during data bit 4 of frame 8'hC3 -> all outputs go to reset values the next cycle, no DV for the aborted frame. A subsequent clean frame 8'h7E yields DV with byte 8'h7E.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, 2-flop input synchronizer, mid-bit sampling.
// Emits a one-cycle valid pulse per good byte and a one-cycle framing-error pulse.
module uart_rx #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    localparam logic [9:0] HALF = 10'((CLKS_PER_BIT - 1) / 2);
    localparam logic [9:0] LAST = 10'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_CLEANUP,
        S_WAIT_HIGH
    } state_e;

    state_e      state_q;
    logic        rx_meta_q;
    logic        rx_s_q;
    logic [9:0]  cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  byte_q;
    logic        dv_q;
    logic        act_q;
    logic        ferr_q;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx_Serial;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
            act_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            dv_q   <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    idx_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF) begin
                        cnt_q <= '0;
                        if (!rx_s_q) begin
                            act_q   <= 1'b1;
                            state_q <= S_DATA;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q          <= '0;
                        shift_q[idx_q] <= rx_s_q;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (rx_s_q) begin
                            byte_q  <= shift_q;
                            dv_q    <= 1'b1;
                            state_q <= S_CLEANUP;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 10'd1;
                    end
                end
                S_CLEANUP: begin
                    act_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                // A held-low line must yield only one error, so wait for idle.
                S_WAIT_HIGH: begin
                    act_q <= 1'b0;
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    act_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Active    = act_q;
    assign o_Rx_Frame_Err = ferr_q;

endmodule
